// File: rtl/x_ddr_out_sched_pkg.sv
// Shared types for the DDR output scheduler: FSM states, source id, beat-counter sizing.
package x_ddr_out_sched_pkg;

    typedef enum logic [1:0] {
        ST_INITP = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    typedef logic src_t;

    // Beat counter must index WIDTH/2 pairs; never narrower than one bit.
    function automatic int unsigned beat_w(input int unsigned width);
        int unsigned w;
        w = $clog2(width / 2);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/x_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant/ready with a registered last-winner pointer.
module x_rr_arb2
    import x_ddr_out_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       win,
    input  logic [1:0] valid,
    output src_t       grant_c,
    output logic [1:0] ready_c,
    output logic       accept_c
);

    src_t ptr;

    // On contention the source that did not win last time gets the grant.
    always_comb begin
        grant_c  = 1'b0;
        ready_c  = 2'b00;
        accept_c = win & (|valid);
        if (valid == 2'b11) begin
            grant_c = ~ptr;
        end else if (valid[1]) begin
            grant_c = 1'b1;
        end
        if (accept_c) begin
            ready_c[grant_c] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b1;
        end else if (accept_c) begin
            ptr <= grant_c;
        end
    end

endmodule

// File: rtl/x_ddr_out_sched.sv
// Arbitrates two word sources onto one DDR output register, two bits per clock,
// and sequences the register's CLR/PRE after reset.
module x_ddr_out_sched
    import x_ddr_out_sched_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter logic        INIT     = 1'b0,
    parameter logic        IDLE_VAL = 1'b0,
    parameter logic        IDLE_CE  = 1'b1
) (
    input  logic             C,
    input  logic             R,
    input  logic             EN,
    input  logic             S0_VALID,
    output logic             S0_READY,
    input  logic [WIDTH-1:0] S0_DATA,
    input  logic             S1_VALID,
    output logic             S1_READY,
    input  logic [WIDTH-1:0] S1_DATA,
    output logic             D0,
    output logic             D1,
    output logic             CE,
    output logic             CLR,
    output logic             PRE,
    output logic             BUSY,
    output logic             GNT
);

    localparam int unsigned       BEAT_W    = beat_w(WIDTH);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WIDTH / 2 - 1);

    state_t            state, state_n;
    logic [BEAT_W-1:0] beat, beat_n;
    logic [WIDTH-1:0]  shreg, shreg_n;
    logic              d0_n, d1_n, ce_n, clr_n, pre_n, busy_n, gnt_n;

    logic              win_c;
    logic              accept_c;
    src_t              grant_c;
    logic [1:0]        ready_c;
    logic [WIDTH-1:0]  word_c;

    // New words are taken only when idle or on the final beat, so streams stay gap-free.
    assign win_c = EN & ~R &
                   ((state == ST_IDLE) || ((state == ST_SHIFT) && (beat == BEAT_LAST)));

    x_rr_arb2 u_arb (
        .clk      (C),
        .rst      (R),
        .win      (win_c),
        .valid    ({S1_VALID, S0_VALID}),
        .grant_c  (grant_c),
        .ready_c  (ready_c),
        .accept_c (accept_c)
    );

    assign S0_READY = ready_c[0];
    assign S1_READY = ready_c[1];
    assign word_c   = grant_c ? S1_DATA : S0_DATA;

    // Next state and next registered outputs; outputs describe the state being entered.
    always_comb begin
        state_n = state;
        beat_n  = beat;
        shreg_n = shreg;
        d0_n    = D0;
        d1_n    = D1;
        ce_n    = CE;
        clr_n   = CLR;
        pre_n   = PRE;
        busy_n  = BUSY;
        gnt_n   = GNT;

        unique case (state)
            ST_IDLE, ST_SHIFT: begin
                if (accept_c) begin
                    state_n = ST_SHIFT;
                    beat_n  = '0;
                    shreg_n = word_c >> 2;
                    d0_n    = word_c[0];
                    d1_n    = word_c[1];
                    ce_n    = 1'b1;
                    clr_n   = 1'b0;
                    pre_n   = 1'b0;
                    busy_n  = 1'b1;
                    gnt_n   = grant_c;
                end else if ((state == ST_SHIFT) && (beat != BEAT_LAST)) begin
                    beat_n  = beat + BEAT_W'(1);
                    shreg_n = shreg >> 2;
                    d0_n    = shreg[0];
                    d1_n    = shreg[1];
                end else begin
                    state_n = ST_IDLE;
                    beat_n  = '0;
                    d0_n    = IDLE_VAL;
                    d1_n    = IDLE_VAL;
                    ce_n    = IDLE_CE;
                    clr_n   = 1'b0;
                    pre_n   = 1'b0;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                beat_n  = '0;
                d0_n    = IDLE_VAL;
                d1_n    = IDLE_VAL;
                ce_n    = IDLE_CE;
                clr_n   = 1'b0;
                pre_n   = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state <= ST_INITP;
            beat  <= '0;
            shreg <= '0;
            D0    <= INIT;
            D1    <= INIT;
            CE    <= 1'b0;
            CLR   <= ~INIT;
            PRE   <= INIT;
            BUSY  <= 1'b0;
            GNT   <= 1'b0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
            shreg <= shreg_n;
            D0    <= d0_n;
            D1    <= d1_n;
            CE    <= ce_n;
            CLR   <= clr_n;
            PRE   <= pre_n;
            BUSY  <= busy_n;
            GNT   <= gnt_n;
        end
    end

endmodule

// File: tb/tb_x_ddr_out_sched.sv
// Directed bench for x_ddr_out_sched: init sequencing, serialization, streaming,
// contention, EN gating and mid-word reset.
module tb_x_ddr_out_sched;

    logic       C = 1'b0;
    logic       R;
    logic       EN;
    logic       S0_VALID, S1_VALID;
    logic [7:0] S0_DATA, S1_DATA;
    logic       S0_READY, S1_READY;
    logic       D0, D1, CE, CLR, PRE, BUSY, GNT;

    logic       p_s0_ready, p_s1_ready;
    logic       p_d0, p_d1, p_ce, p_clr, p_pre, p_busy, p_gnt;

    int n_chk = 0;
    int n_bad = 0;

    always #5 C = ~C;

    x_ddr_out_sched #(.WIDTH(8), .INIT(1'b0), .IDLE_VAL(1'b0), .IDLE_CE(1'b1)) dut (
        .C(C), .R(R), .EN(EN),
        .S0_VALID(S0_VALID), .S0_READY(S0_READY), .S0_DATA(S0_DATA),
        .S1_VALID(S1_VALID), .S1_READY(S1_READY), .S1_DATA(S1_DATA),
        .D0(D0), .D1(D1), .CE(CE), .CLR(CLR), .PRE(PRE), .BUSY(BUSY), .GNT(GNT)
    );

    // INIT=1 instance shares clock and reset; its requesters stay quiet.
    x_ddr_out_sched #(.WIDTH(8), .INIT(1'b1), .IDLE_VAL(1'b0), .IDLE_CE(1'b1)) dut_p (
        .C(C), .R(R), .EN(1'b1),
        .S0_VALID(1'b0), .S0_READY(p_s0_ready), .S0_DATA(8'h00),
        .S1_VALID(1'b0), .S1_READY(p_s1_ready), .S1_DATA(8'h00),
        .D0(p_d0), .D1(p_d1), .CE(p_ce), .CLR(p_clr), .PRE(p_pre), .BUSY(p_busy), .GNT(p_gnt)
    );

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] w;
    logic       src;

    initial begin
        R = 1'b1; EN = 1'b1;
        S0_VALID = 1'b1; S1_VALID = 1'b0; S0_DATA = 8'h00; S1_DATA = 8'h00;

        // Reset/init
        tick(); tick(); tick();
        chk("rst_clr", CLR, 1); chk("rst_pre", PRE, 0); chk("rst_ce", CE, 0);
        chk("rst_d0", D0, 0); chk("rst_d1", D1, 0); chk("rst_busy", BUSY, 0);
        chk("rst_ready0", S0_READY, 0);
        chk("p_rst_pre", p_pre, 1); chk("p_rst_clr", p_clr, 0);
        chk("p_rst_d0", p_d0, 1); chk("p_rst_d1", p_d1, 1); chk("p_rst_ce", p_ce, 0);
        R = 1'b0;
        #1;
        chk("initp_clr", CLR, 1); chk("initp_ce", CE, 0); chk("initp_ready0", S0_READY, 0);
        chk("p_initp_pre", p_pre, 1);
        S0_VALID = 1'b0;
        tick();
        chk("idle_clr", CLR, 0); chk("idle_pre", PRE, 0); chk("idle_ce", CE, 1);
        chk("idle_d0", D0, 0); chk("idle_d1", D1, 0); chk("idle_busy", BUSY, 0);
        chk("p_idle_pre", p_pre, 0); chk("p_idle_d0", p_d0, 0); chk("p_idle_ce", p_ce, 1);

        // Single word 0xB4 from S0
        S0_VALID = 1'b1; S0_DATA = 8'hB4;
        #1;
        chk("single_ready0", S0_READY, 1); chk("single_ready1", S1_READY, 0);
        tick();
        S0_VALID = 1'b0;
        w = 8'hB4;
        for (int b = 0; b < 4; b++) begin
            chk("single_d0", D0, w[2*b]); chk("single_d1", D1, w[2*b+1]);
            chk("single_busy", BUSY, 1); chk("single_gnt", GNT, 0); chk("single_ce", CE, 1);
            tick();
        end
        chk("single_done_busy", BUSY, 0); chk("single_done_d0", D0, 0);

        // Back-to-back 0xFF then 0x00 from S0
        S0_VALID = 1'b1; S0_DATA = 8'hFF;
        #1;
        chk("b2b_ready_first", S0_READY, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            w = (i < 4) ? 8'hFF : 8'h00;
            if (i == 3) S0_DATA = 8'h00;
            if (i == 4) S0_VALID = 1'b0;
            #1;
            chk("b2b_busy", BUSY, 1);
            chk("b2b_d0", D0, w[2*(i%4)]); chk("b2b_d1", D1, w[2*(i%4)+1]);
            chk("b2b_ready", S0_READY, (i == 3) ? 1 : 0);
            tick();
        end
        chk("b2b_done_busy", BUSY, 0);

        // EN drop during beat 1 of 0x5A
        S0_VALID = 1'b1; S0_DATA = 8'h5A;
        #1;
        chk("en_ready0", S0_READY, 1);
        tick();
        S0_VALID = 1'b0;
        w = 8'h5A;
        for (int b = 0; b < 4; b++) begin
            if (b == 1) begin
                EN = 1'b0; S0_VALID = 1'b1; S1_VALID = 1'b1; S1_DATA = 8'hC3;
            end
            #1;
            chk("en_busy", BUSY, 1);
            chk("en_d0", D0, w[2*b]); chk("en_d1", D1, w[2*b+1]);
            chk("en_ready0_blk", S0_READY, 0); chk("en_ready1_blk", S1_READY, 0);
            tick();
        end
        chk("en_idle_busy", BUSY, 0); chk("en_idle_ready1", S1_READY, 0);
        tick();
        chk("en_hold_busy", BUSY, 0);
        EN = 1'b1;
        #1;
        chk("en_resume_ready1", S1_READY, 1); chk("en_resume_ready0", S0_READY, 0);
        tick();
        S0_VALID = 1'b0; S1_VALID = 1'b0;
        chk("en_resume_gnt", GNT, 1); chk("en_resume_busy", BUSY, 1);
        chk("en_resume_d0", D0, 1); chk("en_resume_d1", D1, 1);
        tick();
        chk("en_resume_b1_d0", D0, 0); chk("en_resume_b1_d1", D1, 0);

        // Reset at beat 2 of the S1 word
        tick();
        chk("rmid_busy_pre", BUSY, 1);
        R = 1'b1;
        tick();
        chk("rmid_ce", CE, 0); chk("rmid_clr", CLR, 1); chk("rmid_busy", BUSY, 0);
        chk("rmid_d0", D0, 0);
        R = 1'b0;
        S0_VALID = 1'b1; S0_DATA = 8'h0F; S1_VALID = 1'b1; S1_DATA = 8'hF0;
        #1;
        chk("rmid_initp_ready0", S0_READY, 0); chk("rmid_initp_ready1", S1_READY, 0);
        tick();

        // Contention: S0, S1, S0, S1 with both held valid
        chk("cont_idle_clr", CLR, 0);
        chk("cont_first_ready0", S0_READY, 1); chk("cont_first_ready1", S1_READY, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            src = 1'(k % 2);
            w = src ? 8'hF0 : 8'h0F;
            for (int b = 0; b < 4; b++) begin
                chk("cont_gnt", GNT, src); chk("cont_busy", BUSY, 1);
                chk("cont_d0", D0, w[2*b]); chk("cont_d1", D1, w[2*b+1]);
                chk("cont_ready0", S0_READY, (b == 3 && src == 1'b1) ? 1 : 0);
                chk("cont_ready1", S1_READY, (b == 3 && src == 1'b0) ? 1 : 0);
                tick();
            end
        end
        S0_VALID = 1'b0; S1_VALID = 1'b0;
        chk("cont_tail_gnt", GNT, 0); chk("cont_tail_d0", D0, 1);
        tick(); tick(); tick(); tick();
        chk("cont_end_busy", BUSY, 0); chk("cont_end_ce", CE, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
